oledrgb_axil_regs: RTL

- AXI4-Lite responder (slave) for the OLEDrgb peripheral.
- Terminates transactions from the AXI VIP master / PS interconnect.
- Holds four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC.
- Exports register contents plus per-register one-cycle write strobes to the OLED drive logic.

---
 rtl/oledrgb_pkg.sv | 29 ++
 rtl/oledrgb_byte_merge.sv | 24 ++
 rtl/oledrgb_axil_regs.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/oledrgb_pkg.sv
// Shared types and constants for the OLEDrgb AXI4-Lite register block.
//   wr_state_t / rd_state_t : write- and read-channel FSM states
//   NUM_REGS, REG_IDX_W     : register file geometry
//   AXI_RESP_OKAY           : the only response code this block returns
package oledrgb_pkg;

  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned REG_IDX_W = 2;
  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  // One-hot select of a register index
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
    reg_onehot      = '0;
    reg_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/oledrgb_byte_merge.sv
// Byte-lane merge of new write data into an existing register word.
//   old_data : current register contents
//   new_data : incoming write data
//   strb     : per-byte enables, 1 selects the new byte
//   merged_c : combinational merged word
module oledrgb_byte_merge #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_data,
  input  logic [DATA_W-1:0]   new_data,
  input  logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0]   merged_c
);

  localparam int unsigned NUM_BYTES = DATA_W / 8;

  always_comb begin
    merged_c = old_data;
    for (int b = 0; b < int'(NUM_BYTES); b++) begin
      if (strb[b]) merged_c[8*b +: 8] = new_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/oledrgb_axil_regs.sv
// AXI4-Lite responder holding four 32-bit registers for the OLEDrgb drive logic.
//   ACLK/ARESET    : clock, synchronous active-high reset
//   S_AXI_*        : AXI4-Lite slave channels (AW, W, B, AR, R)
//   reg_out        : live register contents, index 0..3
//   reg_wr_pulse   : one-cycle strobe per register on each write commit
module oledrgb_axil_regs
  import oledrgb_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                                         ACLK,
  input  logic                                         ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_AWADDR,
  input  logic [2:0]                                   S_AXI_AWPROT,
  input  logic                                         S_AXI_AWVALID,
  output logic                                         S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]              S_AXI_WSTRB,
  input  logic                                         S_AXI_WVALID,
  output logic                                         S_AXI_WREADY,
  output logic [1:0]                                   S_AXI_BRESP,
  output logic                                         S_AXI_BVALID,
  input  logic                                         S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_ARADDR,
  input  logic [2:0]                                   S_AXI_ARPROT,
  input  logic                                         S_AXI_ARVALID,
  output logic                                         S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_RDATA,
  output logic [1:0]                                   S_AXI_RRESP,
  output logic                                         S_AXI_RVALID,
  input  logic                                         S_AXI_RREADY,
  output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0]  reg_out,
  output logic [NUM_REGS-1:0]                          reg_wr_pulse
);

  localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
  localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;

  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DW-1:0]              rdata_q;
  logic [NUM_REGS-1:0]        pulse_q, pulse_d;
  logic [NUM_REGS-1:0][DW-1:0] regs_q;

  // Holding buffers for a write half that arrives before its partner
  logic [REG_IDX_W-1:0] aw_idx_q;
  logic [DW-1:0]        w_data_q;
  logic [STRB_W-1:0]    w_strb_q;

  logic                 aw_hs, w_hs, ar_hs, commit_c;
  logic [REG_IDX_W-1:0] commit_idx, rd_idx;
  logic [DW-1:0]        commit_data, merged_c;
  logic [STRB_W-1:0]    commit_strb;
  logic                 unused_bits;

  assign aw_hs = S_AXI_AWVALID & awready_q;
  assign w_hs  = S_AXI_WVALID  & wready_q;
  assign ar_hs = S_AXI_ARVALID & arready_q;

  // Live bus values unless that half was latched in an earlier cycle
  assign commit_idx  = (wr_state_q == W_HAVE_AW) ? aw_idx_q : S_AXI_AWADDR[REG_IDX_W+1:2];
  assign commit_data = (wr_state_q == W_HAVE_W)  ? w_data_q : S_AXI_WDATA;
  assign commit_strb = (wr_state_q == W_HAVE_W)  ? w_strb_q : S_AXI_WSTRB;
  assign rd_idx      = S_AXI_ARADDR[REG_IDX_W+1:2];

  oledrgb_byte_merge #(.DATA_W(DW)) u_merge (
    .old_data (regs_q[commit_idx]),
    .new_data (commit_data),
    .strb     (commit_strb),
    .merged_c (merged_c)
  );

  // Write channel next state and next registered outputs
  always_comb begin
    wr_state_d = wr_state_q;
    commit_c   = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit_c   = 1'b1;
          wr_state_d = W_RESP;
        end else if (aw_hs) begin
          wr_state_d = W_HAVE_AW;
        end else if (w_hs) begin
          wr_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          commit_c   = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          commit_c   = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
    awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_W);
    wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_AW);
    bvalid_d  = (wr_state_d == W_RESP);
    pulse_d   = commit_c ? reg_onehot(commit_idx) : '0;
  end

  // Write channel state, outputs, holding buffers and register file
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      pulse_q    <= '0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      regs_q     <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      pulse_q    <= pulse_d;
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[REG_IDX_W+1:2];
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (commit_c) regs_q[commit_idx] <= merged_c;
    end
  end

  // Read channel next state and next registered outputs
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (ar_hs) rd_state_d = R_RESP;
      R_RESP:  if (S_AXI_RREADY) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
    arready_d = (rd_state_d == R_IDLE);
    rvalid_d  = (rd_state_d == R_RESP);
  end

  // Read channel state and outputs; RDATA samples pre-commit register values
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      if (ar_hs) rdata_q <= regs_q[rd_idx];
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = AXI_RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = AXI_RESP_OKAY;
  assign reg_out       = regs_q;
  assign reg_wr_pulse  = pulse_q;

  // Protection bits and byte offset within a word carry no meaning here
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
